// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_master_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone signal bundle for wb_cmd_master.
interface wb_cmd_master_if
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    localparam int unsigned SW = DW / 8;

    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [SW-1:0] cmd_sel_i;

    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;

    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_tmo_ctr.sv
// Ack wait counter; expired_c flags the last allowed BUS cycle (count == TMO_CYCLES-1).
module wb_tmo_ctr
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [TMO_W-1:0] cnt;

    assign expired_c = en && (cnt == TMO_W'(TMO_CYCLES - 1));

    // Saturates at the expiry value so a held enable cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired_c) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, result on a response port.
// Optional ack timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    wb_cmd_master_if.master bus
);

    state_t state;
    logic   accept_c;

    assign accept_c = (state == ST_IDLE) && bus.cmd_valid_i && bus.cmd_ready_o;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic tmo_expired_c;
    logic timeout_c;

    wb_tmo_ctr #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .clr       (accept_c),
        .en        (state == ST_BUS),
        .expired_c (tmo_expired_c)
    );

    // A simultaneous ack takes priority over expiry
    assign timeout_c = tmo_expired_c && !bus.wb_ack_i;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_W'(TMO_CYCLES);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= ST_IDLE;
            bus.cmd_ready_o <= 1'b0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_dat_o   <= '0;
            bus.rsp_err_o   <= 1'b0;
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
            bus.wb_we_o     <= 1'b0;
            bus.wb_adr_o    <= '0;
            bus.wb_dat_o    <= '0;
            bus.wb_sel_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.cmd_ready_o <= 1'b1;
                    if (accept_c) begin
                        bus.cmd_ready_o <= 1'b0;
                        bus.wb_we_o     <= bus.cmd_we_i;
                        bus.wb_adr_o    <= bus.cmd_adr_i;
                        bus.wb_dat_o    <= bus.cmd_dat_i;
                        bus.wb_sel_o    <= bus.cmd_sel_i;
                        bus.wb_cyc_o    <= 1'b1;
                        bus.wb_stb_o    <= 1'b1;
                        state           <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (bus.wb_ack_i) begin
                        bus.wb_cyc_o    <= 1'b0;
                        bus.wb_stb_o    <= 1'b0;
                        bus.rsp_dat_o   <= bus.wb_we_o ? '0 : bus.wb_dat_i;
                        bus.rsp_err_o   <= 1'b0;
                        bus.rsp_valid_o <= 1'b1;
                        state           <= ST_RESP;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else if (timeout_c) begin
                        bus.wb_cyc_o    <= 1'b0;
                        bus.wb_stb_o    <= 1'b0;
                        bus.rsp_dat_o   <= '0;
                        bus.rsp_err_o   <= 1'b1;
                        bus.rsp_valid_o <= 1'b1;
                        state           <= ST_RESP;
                    end
`endif
                end

                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                        bus.cmd_ready_o <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized self-checking bench for wb_cmd_master against a transaction-level memory model.
module tb_wb_cmd_master;

    localparam int unsigned TMO      = 8;
    localparam logic [31:0] MAP_TOP  = 32'h0008_0000;
    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] ref_mem  [bit [31:0]];
    logic [31:0] slv_mem  [bit [31:0]];
    logic [31:0] last_dat;

    wb_cmd_master_if #(.AW(32), .DW(32)) bus ();

    wb_cmd_master #(
        .AW         (32),
        .DW         (32),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] adr);
        if (adr >= MAP_TOP) return UNMAPPED;
        return ref_mem.exists(adr) ? ref_mem[adr] : 32'h0;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] adr);
        if (adr >= MAP_TOP) return UNMAPPED;
        return slv_mem.exists(adr) ? slv_mem[adr] : 32'h0;
    endfunction

    // One full transaction: issue, serve the bus with wait_n wait states, then drain with backpressure
    task automatic do_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int wait_n, input bit ack_en,
                          input int bp, input bit hold_valid, input bit spur);
        int          nb;
        bit          timed_out;
        int          exp_nb;
        logic [31:0] exp_dat;
        timed_out = TMO_EN && (!ack_en || wait_n >= int'(TMO));
        exp_nb    = timed_out ? int'(TMO) : wait_n + 1;
        exp_dat   = (timed_out || we) ? 32'h0 : ref_rd(adr);
        if (!timed_out && we && adr < MAP_TOP) ref_mem[adr] = merge(ref_rd(adr), dat, sel);

        chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        @(posedge clk); #1;
        bus.cmd_valid_i = hold_valid;

        nb = 0;
        while (bus.wb_cyc_o && nb < 200) begin
            chk("wb_stb", 32'(bus.wb_stb_o), 32'd1);
            chk("wb_we", 32'(bus.wb_we_o), 32'(we));
            chk("wb_adr", bus.wb_adr_o, adr);
            chk("wb_dat", bus.wb_dat_o, dat);
            chk("wb_sel", 32'(bus.wb_sel_o), 32'(sel));
            chk("cmd_ready_bus", 32'(bus.cmd_ready_o), 32'd0);
            bus.wb_ack_i = ack_en && (nb == wait_n);
            if (bus.wb_ack_i) begin
                bus.wb_dat_i = slv_rd(bus.wb_adr_o);
                if (bus.wb_we_o && bus.wb_adr_o < MAP_TOP)
                    slv_mem[bus.wb_adr_o] = merge(slv_rd(bus.wb_adr_o), bus.wb_dat_o, bus.wb_sel_o);
            end else begin
                bus.wb_dat_i = $urandom;
            end
            @(posedge clk); #1;
            bus.wb_ack_i = 1'b0;
            nb++;
        end
        chk("bus_cycles", 32'(nb), 32'(exp_nb));
        chk("wb_stb_drop", 32'(bus.wb_stb_o), 32'd0);
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(timed_out));
        chk("rsp_dat", bus.rsp_dat_o, exp_dat);

        repeat (bp) begin
            if (spur) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = $urandom;
            end
            @(posedge clk); #1;
            bus.wb_ack_i = 1'b0;
            chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
            chk("bp_rsp_dat", bus.rsp_dat_o, exp_dat);
            chk("bp_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
            chk("bp_no_cyc", 32'(bus.wb_cyc_o), 32'd0);
        end

        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        chk("rsp_valid_clr", 32'(bus.rsp_valid_o), 32'd0);
        chk("cmd_ready_back", 32'(bus.cmd_ready_o), 32'd1);
        last_dat = exp_dat;
    endtask

    initial begin
        bit          we;
        logic [31:0] adr;
        int          wn;
        bit          ae;

        clk = 1'b0;
        rst_n = 1'b0;
        n_checks = 0;
        n_fail = 0;
        last_dat = 32'h0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wb_dat_i    = '0;
        bus.wb_ack_i    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        chk("rst_rsp_dat", bus.rsp_dat_o, 32'd0);
        chk("rst_cyc_stb_we", 32'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 32'd0);
        chk("rst_adr", bus.wb_adr_o, 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

        // Directed: write with 2 waits, zero-wait read, unmapped read
        do_cmd(1'b1, 32'h0002_0004, 32'hA5A5_5A5A, 4'hF, 2, 1'b1, 0, 1'b0, 1'b0);
        slv_mem[32'h0004_0000] = 32'h1234_5678;
        ref_mem[32'h0004_0000] = 32'h1234_5678;
        do_cmd(1'b0, 32'h0004_0000, 32'h0, 4'hF, 0, 1'b1, 0, 1'b0, 1'b0);
        do_cmd(1'b0, 32'h0010_0000, 32'h0, 4'hF, 1, 1'b1, 0, 1'b0, 1'b0);

        // Backpressure with command held, spurious acks in RESP
        do_cmd(1'b0, 32'h0002_0004, 32'h0, 4'hF, 1, 1'b1, 10, 1'b1, 1'b1);

        if (TMO_EN) begin
            do_cmd(1'b0, 32'h0002_0004, 32'h0, 4'hF, 0, 1'b0, 1, 1'b0, 1'b0);
            do_cmd(1'b0, 32'h0002_0004, 32'h0, 4'hF, int'(TMO) - 1, 1'b1, 1, 1'b0, 1'b0);
        end

        // Spurious acks in IDLE must not disturb anything
        repeat (3) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = $urandom;
            @(posedge clk); #1;
            bus.wb_ack_i = 1'b0;
            chk("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
            chk("idle_rsp_dat", bus.rsp_dat_o, last_dat);
            chk("idle_cyc", 32'(bus.wb_cyc_o), 32'd0);
        end

        // Reset in the middle of a bus cycle
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0002_0008;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        chk("mid_cyc_up", 32'(bus.wb_cyc_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_cyc_stb", 32'({bus.wb_cyc_o, bus.wb_stb_o}), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("post_rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("post_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        last_dat = 32'h0;

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = ($urandom_range(0, 9) == 0) ? 32'h00F0_0010
                                               : 32'h0002_0000 + 32'($urandom_range(0, 7)) * 32'd4;
            wn  = TMO_EN ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 4));
            ae  = TMO_EN ? ($urandom_range(0, 4) != 0) : 1'b1;
            do_cmd(we, adr, $urandom, 4'($urandom_range(1, 15)), wn, ae,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
